pipelined_shifter: RTL

//  Parametrised, pipelined barrel shifter for the ALU/execute path; successor to the 32-bit combinational shifter.

---
 rtl/shifter_pkg.sv | 33 +++
 rtl/pipelined_shifter_shift_level.sv | 38 +++
 rtl/pipelined_shifter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation codes and
// the helpers that spread the shift levels over the pipeline stages.
package shifter_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_SLL = 3'b000;
  localparam logic [OP_W-1:0] OP_SRL = 3'b001;
  localparam logic [OP_W-1:0] OP_SRA = 3'b010;
  localparam logic [OP_W-1:0] OP_ROL = 3'b011;
  localparam logic [OP_W-1:0] OP_ROR = 3'b100;

  // First shift level handled by stage s. Levels are split as evenly as
  // possible and the leading stages absorb the remainder, one extra each.
  function automatic int stage_first_level(int s, int nl, int ns);
    int base;
    int extra;
    base  = nl / ns;
    extra = nl % ns;
    return s * base + ((s < extra) ? s : extra);
  endfunction

  // Stage index that owns shift level l.
  function automatic int level_stage(int l, int nl, int ns);
    int st;
    st = 0;
    for (int s = 0; s < ns; s++) begin
      if (l >= stage_first_level(s, nl, ns)) st = s;
    end
    return st;
  endfunction

endpackage

// File: rtl/pipelined_shifter_shift_level.sv
// One combinational right-shift level of distance DIST. The vacated bits are
// filled with 'fill' (zero or sign), or with the wrapped-around low bits when
// rotating. Rotation hardware exists only when SHIFTER_ROTATE_EN is defined.
module shift_level #(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic             fill,
  input  logic             rot,
  output logic [WIDTH-1:0] res
);

  logic [WIDTH-1:0] shifted;

  // Plain right shift with the selected fill bit
  assign shifted = {{DIST{fill}}, data[WIDTH-1:DIST]};

`ifdef SHIFTER_ROTATE_EN
  logic [WIDTH-1:0] rotated;

  // Right rotate: the low bits wrap to the top
  assign rotated = {data[DIST-1:0], data[WIDTH-1:DIST]};

  // Level applied only when this distance bit of the shift amount is set
  assign res = !en ? data : (rot ? rotated : shifted);
`else
  logic unused_rot;

  // Rotate select is meaningless without the rotate datapath
  assign unused_rot = rot;

  // Level applied only when this distance bit of the shift amount is set
  assign res = en ? shifted : data;
`endif

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with valid/ready on both
// sides. Left operations are done as bit-reverse -> right shift -> bit-reverse.
// The log2(WIDTH) shift levels are distributed over PIPE_STAGES registers and
// the last register drives the outputs directly.
// Optional feature: define SHIFTER_ROTATE_EN to build ROL/ROR; without it
// those opcodes are reported as illegal (data unshifted, out_err = 1).
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic [OP_W-1:0]          in_op,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_err
);

  localparam int SHW = $clog2(WIDTH);
  localparam int NL  = SHW;
  localparam int NS  = PIPE_STAGES;

  // Pipeline registers, one slot per stage
  logic [NS-1:0][WIDTH-1:0] data_reg;
  logic [NS-1:0][SHW-1:0]   shamt_reg;
  logic [NS-1:0][TAG_W-1:0] tag_reg;
  logic [NS-1:0]            fill_reg;
  logic [NS-1:0]            rot_reg;
  logic [NS-1:0]            rev_reg;
  logic [NS-1:0]            err_reg;
  logic [NS-1:0]            valid_reg;

  // Values presented to each stage (decoded input or previous register)
  logic [NS-1:0][WIDTH-1:0] st_data;
  logic [NS-1:0][SHW-1:0]   st_shamt;
  logic [NS-1:0][TAG_W-1:0] st_tag;
  logic [NS-1:0]            st_fill;
  logic [NS-1:0]            st_rot;
  logic [NS-1:0]            st_rev;
  logic [NS-1:0]            st_err;
  logic [NS-1:0]            st_valid;
  logic [NS-1:0][WIDTH-1:0] nxt_data;
  logic [NS-1:0]            adv;

  logic             in_legal;
  logic             in_left;
  logic             in_rot;
  logic [WIDTH-1:0] in_data_rev;
  logic             unused_ctrl;

  // Opcode decode: legality, direction and rotate selection
  always_comb begin
    in_legal = 1'b0;
    in_left  = 1'b0;
    in_rot   = 1'b0;
    case (in_op)
      OP_SLL: begin
        in_legal = 1'b1;
        in_left  = 1'b1;
      end
      OP_SRL, OP_SRA: in_legal = 1'b1;
`ifdef SHIFTER_ROTATE_EN
      OP_ROL: begin
        in_legal = 1'b1;
        in_left  = 1'b1;
        in_rot   = 1'b1;
      end
      OP_ROR: begin
        in_legal = 1'b1;
        in_rot   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign in_data_rev = {<<{in_data}};

  // Shift levels chained through the stages; a level that opens a stage
  // reads that stage's inputs, the others read the previous level.
  genvar gi;
  generate
    for (gi = 0; gi < NL; gi++) begin : g_level
      localparam int S = level_stage(gi, NL, NS);
      logic [WIDTH-1:0] src;
      logic [WIDTH-1:0] res;
      if (gi == stage_first_level(S, NL, NS)) begin : g_head
        assign src = st_data[S];
      end else begin : g_chain
        assign src = g_level[gi-1].res;
      end
      shift_level #(
        .WIDTH(WIDTH),
        .DIST (1 << gi)
      ) u_level (
        .data(src),
        .en  (st_shamt[S][gi]),
        .fill(st_fill[S]),
        .rot (st_rot[S]),
        .res (res)
      );
    end

    for (gi = 0; gi < NS; gi++) begin : g_stage
      localparam int LAST = stage_first_level(gi + 1, NL, NS) - 1;
      if (gi == 0) begin : g_in
        // Illegal ops get a zero distance so the operand passes unshifted
        assign st_data[gi]  = in_left ? in_data_rev : in_data;
        assign st_shamt[gi] = in_legal ? in_shamt : '0;
        assign st_fill[gi]  = (in_op == OP_SRA) & in_data[WIDTH-1];
        assign st_rot[gi]   = in_rot;
        assign st_rev[gi]   = in_left;
        assign st_err[gi]   = !in_legal;
        assign st_tag[gi]   = in_tag;
        assign st_valid[gi] = in_valid;
      end else begin : g_reg
        assign st_data[gi]  = data_reg[gi-1];
        assign st_shamt[gi] = shamt_reg[gi-1];
        assign st_fill[gi]  = fill_reg[gi-1];
        assign st_rot[gi]   = rot_reg[gi-1];
        assign st_rev[gi]   = rev_reg[gi-1];
        assign st_err[gi]   = err_reg[gi-1];
        assign st_tag[gi]   = tag_reg[gi-1];
        assign st_valid[gi] = valid_reg[gi-1];
      end
      if (gi == NS - 1) begin : g_out
        // Undo the input reversal before the output register
        logic [WIDTH-1:0] res_rev;
        assign res_rev      = {<<{g_level[LAST].res}};
        assign nxt_data[gi] = st_rev[gi] ? res_rev : g_level[LAST].res;
      end else begin : g_mid
        assign nxt_data[gi] = g_level[LAST].res;
      end
    end
  endgenerate

  // Stall chain: a stage advances when empty or when its successor advances
  always_comb begin
    logic a;
    adv = '0;
    a   = !valid_reg[NS-1] | out_ready;
    adv[NS-1] = a;
    for (int k = NS - 2; k >= 0; k--) begin
      a      = !valid_reg[k] | a;
      adv[k] = a;
    end
  end

  // Pipeline registers: advance as a unit per stage, payload only on valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg  <= '0;
      shamt_reg <= '0;
      tag_reg   <= '0;
      fill_reg  <= '0;
      rot_reg   <= '0;
      rev_reg   <= '0;
      err_reg   <= '0;
      valid_reg <= '0;
    end else begin
      for (int k = 0; k < NS; k++) begin
        if (adv[k]) begin
          valid_reg[k] <= st_valid[k];
          if (st_valid[k]) begin
            data_reg[k]  <= nxt_data[k];
            shamt_reg[k] <= st_shamt[k];
            tag_reg[k]   <= st_tag[k];
            fill_reg[k]  <= st_fill[k];
            rot_reg[k]   <= st_rot[k];
            rev_reg[k]   <= st_rev[k];
            err_reg[k]   <= st_err[k];
          end
        end
      end
    end
  end

  // Control bits of the final stage and consumed distance bits are dead
  assign unused_ctrl = ^{shamt_reg, fill_reg, rot_reg, rev_reg};

  assign in_ready  = adv[0];
  assign out_valid = valid_reg[NS-1];
  assign out_data  = data_reg[NS-1];
  assign out_tag   = tag_reg[NS-1];
  assign out_err   = err_reg[NS-1];

endmodule
